// File: rtl/led_pattern_engine_if.sv
// Switch/LED bundle between the board inputs and the pattern engine.
interface led_pattern_engine_if #(
    parameter int unsigned WIDTH = 16
);
    logic             speed;
    logic [1:0]       mode;
    logic             pause;
    logic [WIDTH-1:0] led;
    logic             tick;

    modport master (output speed, mode, pause, input led, tick);
    modport slave  (input speed, mode, pause, output led, tick);
endinterface

// File: rtl/led_pattern_engine.sv
// LED bar animator: four patterns stepped by an internal divider at two speeds, with pause.
// led and tick are combinational decodes of the state so a new step is visible right after its edge.
module led_pattern_engine #(
    parameter int unsigned WIDTH    = 16,
    parameter int unsigned FAST_DIV = 25_000_000,
    parameter int unsigned SLOW_DIV = 100_000_000,
    parameter int unsigned CNT_W    = 27
) (
    input logic                  clk,
    input logic                  rst,
    led_pattern_engine_if.slave  bus
);
    localparam int unsigned POS_W  = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam int unsigned FILL_W = $clog2(WIDTH + 1);

    localparam logic [0:0] S_INIT = 1'b0;
    localparam logic [0:0] S_RUN  = 1'b1;

    localparam logic [CNT_W-1:0]  FAST_M1  = CNT_W'(FAST_DIV - 1);
    localparam logic [CNT_W-1:0]  SLOW_M1  = CNT_W'(SLOW_DIV - 1);
    localparam logic [POS_W-1:0]  LAST_POS = POS_W'(WIDTH - 1);
    localparam logic [FILL_W-1:0] FULL     = FILL_W'(WIDTH);
    localparam logic [FILL_W-1:0] FILL_ONE = FILL_W'(1);

    logic [0:0]        state_q, state_d;
    logic [CNT_W-1:0]  cnt_q,   cnt_d;
    logic [POS_W-1:0]  pos_q,   pos_d;
    logic              dir_q,   dir_d;   // 0 = up, 1 = down
    logic [FILL_W-1:0] fill_q,  fill_d;
    logic [1:0]        mode_q,  mode_d;
    logic              speed_q, speed_d;
    logic              first_q, first_d; // first cycle after reset: mode_q/speed_q not yet valid

    logic              mode_chg_c;
    logic              speed_chg_c;
    logic              tick_c;
    logic [CNT_W-1:0]  div_m1_c;
    logic [WIDTH-1:0]  led_c;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_INIT;
            cnt_q   <= '0;
            pos_q   <= '0;
            dir_q   <= 1'b0;
            fill_q  <= FILL_ONE;
            mode_q  <= 2'd0;
            speed_q <= 1'b0;
            first_q <= 1'b1;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            pos_q   <= pos_d;
            dir_q   <= dir_d;
            fill_q  <= fill_d;
            mode_q  <= mode_d;
            speed_q <= speed_d;
            first_q <= first_d;
        end
    end

    // Divider, change detection and pattern stepping
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        pos_d   = pos_q;
        dir_d   = dir_q;
        fill_d  = fill_q;
        mode_d  = bus.mode;
        speed_d = bus.speed;
        first_d = 1'b0;

        mode_chg_c  = !first_q && (state_q == S_RUN) && (bus.mode != mode_q);
        speed_chg_c = !first_q && (bus.speed != speed_q);
        div_m1_c    = bus.speed ? FAST_M1 : SLOW_M1;
        tick_c      = !bus.pause && !mode_chg_c && !speed_chg_c && (cnt_q >= div_m1_c);

        if (mode_chg_c) begin
            cnt_d  = '0;
            pos_d  = (bus.mode == 2'd1) ? LAST_POS : '0;
            dir_d  = 1'b0;
            fill_d = FILL_ONE;
        end else if (speed_chg_c) begin
            cnt_d = '0;
        end else if (!bus.pause) begin
            if (tick_c) begin
                cnt_d = '0;
                if (state_q == S_INIT) begin
                    state_d = S_RUN;
                    pos_d   = (bus.mode == 2'd1) ? LAST_POS : '0;
                    dir_d   = 1'b0;
                    fill_d  = FILL_ONE;
                end else begin
                    case (mode_q)
                        2'd0: pos_d = (pos_q == LAST_POS) ? '0 : pos_q + POS_W'(1);
                        2'd1: pos_d = (pos_q == '0) ? LAST_POS : pos_q - POS_W'(1);
                        2'd2: begin
                            if (!dir_q) begin
                                pos_d = pos_q + POS_W'(1);
                                if (pos_d == LAST_POS) dir_d = 1'b1;
                            end else begin
                                pos_d = pos_q - POS_W'(1);
                                if (pos_d == '0) dir_d = 1'b0;
                            end
                        end
                        default: fill_d = (fill_q == FULL) ? FILL_ONE : fill_q + FILL_W'(1);
                    endcase
                end
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end
    end

    // LED decode: all ones before the first step, then bar fill or one-hot
    always_comb begin
        led_c = '0;
        for (int i = 0; i < int'(WIDTH); i++) begin
            if (state_q == S_INIT) begin
                led_c[i] = 1'b1;
            end else if (mode_q == 2'd3) begin
                led_c[i] = (i < int'(fill_q));
            end else begin
                led_c[i] = (POS_W'(i) == pos_q);
            end
        end
    end

    assign bus.led  = led_c;
    assign bus.tick = tick_c;
endmodule

// File: tb/tb_led_pattern_engine.sv
// Scoreboard bench for led_pattern_engine at WIDTH=4, FAST_DIV=2, SLOW_DIV=4.
module tb_led_pattern_engine;
    typedef struct packed {
        logic [3:0] led;
        logic       tick;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_tests = 0;
    int   n_fail  = 0;
    exp_t exp_q[$];

    led_pattern_engine_if #(.WIDTH(4)) bus ();

    led_pattern_engine #(
        .WIDTH(4), .FAST_DIV(2), .SLOW_DIV(4), .CNT_W(3)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // n samples of one led value; the last one carries tick when last_tick is set
    task automatic push_n(input logic [3:0] led, input int n, input logic last_tick);
        for (int i = 0; i < n; i++) begin
            exp_t e;
            e.led  = led;
            e.tick = last_tick && (i == n - 1);
            exp_q.push_back(e);
        end
    endtask

    task automatic push_hold(input logic [3:0] led, input int n);
        push_n(led, n, 1'b1);
    endtask

    task automatic drain();
        while (exp_q.size() > 0) begin
            exp_t e;
            @(posedge clk);
            @(negedge clk);
            e = exp_q.pop_front();
            chk("led", 32'(bus.led), 32'(e.led));
            chk("tick", 32'(bus.tick), 32'(e.tick));
        end
    endtask

    task automatic startup_seq();
        push_hold(4'b1111, 3);
        push_hold(4'b0001, 4);
        push_hold(4'b0010, 4);
        push_hold(4'b0100, 4);
        push_hold(4'b1000, 4);
        push_hold(4'b0001, 4);
        drain();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.speed = 1'b0;
        bus.mode  = 2'd0;
        bus.pause = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_led", 32'(bus.led), 32'hF);
        chk("rst_tick", 32'(bus.tick), 32'h0);
        rst = 1'b0;
        #1;
        chk("init_led", 32'(bus.led), 32'hF);
        startup_seq();

        // bounce, switched in on a tick cycle
        bus.mode = 2'd2;
        #1 chk("mode2_tick_supp", 32'(bus.tick), 32'h0);
        push_hold(4'b0001, 4);
        push_hold(4'b0010, 4);
        push_hold(4'b0100, 4);
        push_hold(4'b1000, 4);
        push_hold(4'b0100, 4);
        push_hold(4'b0010, 4);
        push_hold(4'b0001, 4);
        push_hold(4'b0010, 4);
        drain();

        // bar fill
        bus.mode = 2'd3;
        #1 chk("mode3_tick_supp", 32'(bus.tick), 32'h0);
        push_hold(4'b0001, 4);
        push_hold(4'b0011, 4);
        push_hold(4'b0111, 4);
        push_hold(4'b1111, 4);
        push_hold(4'b0001, 4);
        drain();

        // rotate right, switched in on a tick cycle
        bus.mode = 2'd1;
        #1 chk("mode1_tick_supp", 32'(bus.tick), 32'h0);
        push_hold(4'b1000, 4);
        push_hold(4'b0100, 4);
        push_n(4'b0010, 3, 1'b0);
        drain();

        // slow -> fast with cnt=2: position held, then steps every 2 clks
        bus.speed = 1'b1;
        #1 chk("speed_up_tick", 32'(bus.tick), 32'h0);
        push_hold(4'b0010, 2);
        push_hold(4'b0001, 2);
        push_hold(4'b1000, 2);
        push_hold(4'b0100, 2);
        drain();

        // fast -> slow on a tick cycle: speed change wins
        bus.speed = 1'b0;
        #1 chk("speed_dn_tick_supp", 32'(bus.tick), 32'h0);
        push_n(4'b0100, 2, 1'b0);
        drain();

        // pause at cnt=1 for 10 clks
        bus.pause = 1'b1;
        #1 chk("pause_tick", 32'(bus.tick), 32'h0);
        push_n(4'b0100, 10, 1'b0);
        drain();
        bus.pause = 1'b0;
        push_hold(4'b0100, 2);
        push_hold(4'b0010, 4);
        push_hold(4'b0001, 4);
        push_n(4'b1000, 2, 1'b0);
        drain();

        // asynchronous reset mid-run
        rst = 1'b1;
        bus.mode = 2'd0;
        #1;
        chk("async_rst_led", 32'(bus.led), 32'hF);
        chk("async_rst_tick", 32'(bus.tick), 32'h0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        #1;
        chk("restart_led", 32'(bus.led), 32'hF);
        startup_seq();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
